// File: rtl/esp32_boot_sequencer.sv
// ESP32 DTR/RTS auto-reset initiator: drives the nDTR/nRTS decoder pair to reboot the
// target into run or ROM-bootloader mode, and passes FTDI lines through when idle.
module esp32_boot_sequencer #(
    parameter int C_reset_cycles  = 2500000,
    parameter int C_boot_cycles   = 1250000,
    parameter int C_settle_cycles = 250000
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       ftdi_ndtr,
    input  logic       ftdi_nrts,
    input  logic       cmd_valid,
    input  logic       cmd_boot,
    output logic       cmd_ready,
    output logic       prog_ndtr,
    output logic       prog_nrts,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int C_max_rb = (C_reset_cycles > C_boot_cycles) ? C_reset_cycles : C_boot_cycles;
    localparam int C_max    = (C_max_rb > C_settle_cycles) ? C_max_rb : C_settle_cycles;
    localparam int CW       = (C_max > 1) ? $clog2(C_max + 1) : 1;

    localparam logic [CW-1:0] C_reset_load  = CW'(C_reset_cycles - 1);
    localparam logic [CW-1:0] C_boot_load   = CW'(C_boot_cycles - 1);
    localparam logic [CW-1:0] C_settle_load = CW'(C_settle_cycles - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RST_HOLD  = 2'd1,
        BOOT_HOLD = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          boot_mode;

    // Handshake: a command is taken on the rising edge where cmd_valid and cmd_ready are
    // both high; cmd_valid at any other time is dropped, never queued.
    assign cmd_ready = (state == IDLE) & ~reset;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            boot_mode <= 1'b0;
            prog_ndtr <= 1'b1;
            prog_nrts <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        boot_mode <= cmd_boot;
                        count     <= C_reset_load;
                        state     <= RST_HOLD;
                        prog_ndtr <= 1'b1;
                        prog_nrts <= 1'b0;
                    end else begin
                        prog_ndtr <= ftdi_ndtr;
                        prog_nrts <= ftdi_nrts;
                    end
                end
                RST_HOLD: begin
                    if (count == '0) begin
                        // Boot mode steps 10 -> 01 so IO0 is low while EN rises.
                        if (boot_mode) begin
                            count     <= C_boot_load;
                            state     <= BOOT_HOLD;
                            prog_ndtr <= 1'b0;
                            prog_nrts <= 1'b1;
                        end else begin
                            count     <= C_settle_load;
                            state     <= SETTLE;
                            prog_ndtr <= 1'b1;
                            prog_nrts <= 1'b1;
                        end
                    end else begin
                        count     <= count - CW'(1);
                        prog_ndtr <= 1'b1;
                        prog_nrts <= 1'b0;
                    end
                end
                BOOT_HOLD: begin
                    if (count == '0) begin
                        count     <= C_settle_load;
                        state     <= SETTLE;
                        prog_ndtr <= 1'b1;
                        prog_nrts <= 1'b1;
                    end else begin
                        count     <= count - CW'(1);
                        prog_ndtr <= 1'b0;
                        prog_nrts <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Outputs stay 11 through the done cycle; passthru shows one cycle later.
                    prog_ndtr <= 1'b1;
                    prog_nrts <= 1'b1;
                    if (count == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    prog_ndtr <= 1'b1;
                    prog_nrts <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Self-checking bench: every cycle is compared against a queue of expected output phases
// built from the reboot recipe (R x 10, B x 01 in boot mode, S x 11, then a done cycle).
module tb_esp32_boot_sequencer;

    localparam int R = 4;
    localparam int B = 3;
    localparam int S = 2;

    logic       clk_25mhz = 1'b0;
    logic       reset     = 1'b1;
    logic       ftdi_ndtr = 1'b1;
    logic       ftdi_nrts = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_boot  = 1'b0;
    logic       cmd_ready;
    logic       prog_ndtr;
    logic       prog_nrts;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected {ndtr, nrts, busy, done} for the current and upcoming cycles.
    logic [3:0] exp_q[$];
    logic [3:0] cur_exp     = 4'b1100;
    logic       model_valid = 1'b0;

    esp32_boot_sequencer #(
        .C_reset_cycles (R),
        .C_boot_cycles  (B),
        .C_settle_cycles(S)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .reset    (reset),
        .ftdi_ndtr(ftdi_ndtr),
        .ftdi_nrts(ftdi_nrts),
        .cmd_valid(cmd_valid),
        .cmd_boot (cmd_boot),
        .cmd_ready(cmd_ready),
        .prog_ndtr(prog_ndtr),
        .prog_nrts(prog_nrts),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: drive inputs after a negedge, advance the model at posedge, compare at negedge.
    task automatic step(input logic v, input logic b, input logic fn, input logic fr, input logic rst);
        reset     = rst;
        cmd_valid = v;
        cmd_boot  = b;
        ftdi_ndtr = fn;
        ftdi_nrts = fr;
        #1;
        if (model_valid) begin
            tests_run++;
            if (cmd_ready !== (~cur_exp[1] & ~rst)) begin
                tests_failed++;
                $display("FAIL cmd_ready t=%0t got=%b want=%b", $time, cmd_ready, ~cur_exp[1] & ~rst);
            end
        end
        @(posedge clk_25mhz);
        if (rst) begin
            exp_q.delete();
            cur_exp     = 4'b1100;
            model_valid = 1'b1;
        end else if (model_valid && !cur_exp[1] && v) begin
            exp_q.delete();
            for (int i = 0; i < R; i++) exp_q.push_back(4'b1010);
            if (b) for (int i = 0; i < B; i++) exp_q.push_back(4'b0110);
            for (int i = 0; i < S; i++) exp_q.push_back(4'b1110);
            exp_q.push_back(4'b1101);
            cur_exp = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
        end else begin
            cur_exp = {fn, fr, 2'b00};
        end
        @(negedge clk_25mhz);
        if (model_valid) begin
            tests_run++;
            if ({prog_ndtr, prog_nrts, busy, done} !== cur_exp) begin
                tests_failed++;
                $display("FAIL seq t=%0t got ndtr/nrts/busy/done=%b want=%b",
                         $time, {prog_ndtr, prog_nrts, busy, done}, cur_exp);
            end
        end
    endtask

    // Accept one command, then run until done, tallying the phases seen while busy.
    task automatic run_seq(input logic b, input logic noise,
                           output int n10, output int n01, output int n11,
                           output int nbusy, output int ndone, output logic timed_out);
        n10 = 0; n01 = 0; n11 = 0; nbusy = 0; ndone = 0; timed_out = 1'b1;
        step(1'b1, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (busy) begin
                nbusy++;
                case ({prog_ndtr, prog_nrts})
                    2'b10:   n10++;
                    2'b01:   n01++;
                    2'b11:   n11++;
                    default: ;
                endcase
            end
            if (done) begin
                ndone++;
                timed_out = 1'b0;
                break;
            end
            step(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
                 noise ? 1'($urandom_range(0, 1)) : 1'b1,
                 noise ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if ({prog_ndtr, prog_nrts, busy, done} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_state got=%b want=1100", {prog_ndtr, prog_nrts, busy, done});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({prog_ndtr, prog_nrts, busy, cmd_ready} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL first_idle got ndtr/nrts/busy/ready=%b want=0101",
                     {prog_ndtr, prog_nrts, busy, cmd_ready});
        end
    endtask

    task automatic check_counts(input string name, input int n10, input int n01, input int n11,
                                input int nbusy, input int ndone, input logic to,
                                input int w10, input int w01, input int w11);
        tests_run++;
        if (to || ndone != 1 || n10 != w10 || n01 != w01 || n11 != w11 || nbusy != w10 + w01 + w11) begin
            tests_failed++;
            $display("FAIL %s got 10x%0d 01x%0d 11x%0d busy=%0d done=%0d timeout=%b want 10x%0d 01x%0d 11x%0d",
                     name, n10, n01, n11, nbusy, ndone, to, w10, w01, w11);
        end
        tests_run++;
        if ({prog_ndtr, prog_nrts} !== 2'b11) begin
            tests_failed++;
            $display("FAIL %s_done_outputs got=%b want=11", name, {prog_ndtr, prog_nrts});
        end
    endtask

    task automatic test_boot_seq();
        int n10, n01, n11, nb, nd;
        logic to, fn, fr;
        run_seq(1'b1, 1'b0, n10, n01, n11, nb, nd, to);
        check_counts("boot_seq", n10, n01, n11, nb, nd, to, R, B, S);
        fn = 1'($urandom_range(0, 1));
        fr = 1'($urandom_range(0, 1));
        step(1'b0, 1'b0, fn, fr, 1'b0);
        tests_run++;
        if ({prog_ndtr, prog_nrts, busy, done} !== {fn, fr, 2'b00}) begin
            tests_failed++;
            $display("FAIL passthru_resume got=%b want=%b", {prog_ndtr, prog_nrts, busy, done}, {fn, fr, 2'b00});
        end
    endtask

    task automatic test_normal_seq();
        int n10, n01, n11, nb, nd;
        logic to;
        run_seq(1'b0, 1'b0, n10, n01, n11, nb, nd, to);
        check_counts("normal_seq", n10, n01, n11, nb, nd, to, R, 0, S);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_busy_ignore();
        int n10, n01, n11, nb, nd;
        logic to;
        for (int k = 0; k < 3; k++) begin
            run_seq(1'(k % 2), 1'b1, n10, n01, n11, nb, nd, to);
            check_counts("busy_ignore", n10, n01, n11, nb, nd, to, R, (k % 2) ? B : 0, S);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_abort();
        int n10, n01, n11, nb, nd;
        logic to;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < R + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if ({prog_ndtr, prog_nrts, busy} !== 3'b011) begin
            tests_failed++;
            $display("FAIL abort_setup got=%b want=011", {prog_ndtr, prog_nrts, busy});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if ({prog_ndtr, prog_nrts, busy, done} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL abort_reset got=%b want=1100", {prog_ndtr, prog_nrts, busy, done});
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_seq(1'b0, 1'b0, n10, n01, n11, nb, nd, to);
        check_counts("after_abort", n10, n01, n11, nb, nd, to, R, 0, S);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        logic prev_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
            tests_run++;
            if ({prog_ndtr, prog_nrts} === 2'b00) begin
                tests_failed++;
                $display("FAIL b2b_no_00 cycle=%0d got=00 want!=00", i);
            end
            if (prev_done) begin
                tests_run++;
                if ({prog_ndtr, prog_nrts, busy} !== 3'b101) begin
                    tests_failed++;
                    $display("FAIL b2b_restart cycle=%0d got=%b want=101", i, {prog_ndtr, prog_nrts, busy});
                end
            end
            if (done) ndone++;
            prev_done = done;
        end
        tests_run++;
        if (ndone < 2) begin
            tests_failed++;
            $display("FAIL b2b_done_count got=%0d want>=2", ndone);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end
    endtask

    initial begin
        @(negedge clk_25mhz);
        test_reset();
        test_boot_seq();
        test_normal_seq();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
